// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads, single-cycle writes, trap entry,
// 64-bit mcycle/minstret. Ports: decode read port, wbk write port, trap, retire, q outs.
module csr_file #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] MHARTID = 32'd0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     rd_adr_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_illegal_o,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            retire_v_i,
  output logic [XLEN-1:0] mepc_q_o,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic [XLEN-1:0] mstatus_q_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            r_st_mie;
  logic            r_st_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;

  logic            w_we;
  logic [XLEN-1:0] w_mstatus;

  // A trap in the same cycle discards the pending write entirely.
  assign w_we = csr_wbk_v_i & ~exception_i;

  // MPP is WARL with only M-mode legal, so it is hardwired to 2'b11.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_st_mpie, 3'b0, r_st_mie, 3'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (exception_i) begin
      r_mepc    <= mepc_i & ~32'h3;
      r_mcause  <= mcause_i;
      r_mtval   <= mtval_i;
      r_st_mpie <= r_st_mie;
      r_st_mie  <= 1'b0;
    end else if (csr_wbk_v_i) begin
      case (csr_adr_i)
        A_MSTATUS: begin
          r_st_mie  <= csr_data_i[3];
          r_st_mpie <= csr_data_i[7];
        end
        A_MIE:      r_mie      <= csr_data_i & 32'h0000_0888;
        A_MTVEC:    r_mtvec    <= csr_data_i & ~32'h3;
        A_MSCRATCH: r_mscratch <= csr_data_i;
        A_MEPC:     r_mepc     <= csr_data_i & ~32'h3;
        A_MCAUSE:   r_mcause   <= csr_data_i;
        A_MTVAL:    r_mtval    <= csr_data_i;
        default: ;
      endcase
    end
  end

  // A write to either half freezes the whole 64-bit counter for that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcycle <= '0;
    end else if (w_we && csr_adr_i == A_MCYCLE) begin
      r_mcycle[31:0] <= csr_data_i;
    end else if (w_we && csr_adr_i == A_MCYCLEH) begin
      r_mcycle[63:32] <= csr_data_i;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_minstret <= '0;
    end else if (w_we && csr_adr_i == A_MINSTRET) begin
      r_minstret[31:0] <= csr_data_i;
    end else if (w_we && csr_adr_i == A_MINSTRETH) begin
      r_minstret[63:32] <= csr_data_i;
    end else if (retire_v_i && !exception_i) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  always_comb begin
    rd_data_o    = '0;
    rd_illegal_o = 1'b0;
    case (rd_adr_i)
      A_MSTATUS:   rd_data_o = w_mstatus;
      A_MISA:      rd_data_o = 32'h4000_0100;
      A_MIE:       rd_data_o = r_mie;
      A_MTVEC:     rd_data_o = r_mtvec;
      A_MSCRATCH:  rd_data_o = r_mscratch;
      A_MEPC:      rd_data_o = r_mepc;
      A_MCAUSE:    rd_data_o = r_mcause;
      A_MTVAL:     rd_data_o = r_mtval;
      A_MCYCLE:    rd_data_o = r_mcycle[31:0];
      A_MCYCLEH:   rd_data_o = r_mcycle[63:32];
      A_MINSTRET:  rd_data_o = r_minstret[31:0];
      A_MINSTRETH: rd_data_o = r_minstret[63:32];
      A_MHARTID:   rd_data_o = MHARTID;
      default:     rd_illegal_o = 1'b1;
    endcase
  end

  assign mepc_q_o    = r_mepc;
  assign mtvec_q_o   = r_mtvec;
  assign mstatus_q_o = w_mstatus;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter XLEN, default 32, data width of every CSR port; only 32 is supported.
REQ-002 Parameter MHARTID, default 0, read-only value returned at 0xF14.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 rd_adr_i  input  12  CSR read address from decode.
REQ-006 rd_data_o  output  XLEN  combinational read data for rd_adr_i.
REQ-007 rd_illegal_o  output  1  rd_adr_i is not an implemented CSR.
REQ-008 csr_wbk_v_i  input  1  CSR write valid, from the exe flopped stage.
REQ-009 csr_adr_i  input  12  CSR write address.
REQ-010 csr_data_i  input  XLEN  CSR write data.
REQ-011 exception_i  input  1  trap taken this cycle.
REQ-012 mcause_i  input  XLEN  trap cause.
REQ-013 mtval_i  input  XLEN  trap value.
REQ-014 mepc_i  input  XLEN  PC of the trapping instruction.
REQ-015 retire_v_i  input  1  one instruction retired this cycle.
REQ-016 mepc_q_o  output  XLEN  current mepc, driven from the flop.
REQ-017 mtvec_q_o  output  XLEN  current mtvec, driven from the flop.
REQ-018 mstatus_q_o  output  XLEN  current mstatus, driven from the flop.

Function
REQ-019 Implemented CSRs SHALL be:
- mstatus 0x300
- misa 0x301
- mie 0x304
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mtval 0x343
- mcycle 0xB00 / mcycleh 0xB80
- minstret 0xB02 / minstreth 0xB82
- mhartid 0xF14
REQ-020 Reads SHALL be combinational with zero latency; unimplemented address -> rd_data_o=0, rd_illegal_o=1.
REQ-021 Writes SHALL become visible on rd_data_o and *_q_o the cycle after csr_wbk_v_i; no internal read-after-write bypass.
REQ-022 Writes to misa, mhartid or unimplemented addresses SHALL be ignored.
REQ-023 mstatus writable bits SHALL be MIE[3], MPIE[7], MPP[12:11]; all other bits read 0.
REQ-024 MPP SHALL be WARL: any written value other than 2'b11 stores 2'b11.
REQ-025 mtvec[1:0] and mepc[1:0] SHALL always read 0; direct trap mode only.
REQ-026 mie writable bits SHALL be [3], [7], [11]; all other bits read 0.
REQ-027 misa SHALL read 0x40000100 (RV32I).
REQ-028 On exception_i, same edge:
- mepc <= mepc_i & ~3
- mcause <= mcause_i
- mtval <= mtval_i
- mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11
REQ-029 exception_i and csr_wbk_v_i in the same cycle: exception wins and the CSR write SHALL be discarded entirely, including non-trap CSRs.
REQ-030 mcycle SHALL be a 64-bit counter incremented every cycle; it wraps from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-031 minstret SHALL be a 64-bit counter incremented when retire_v_i & ~exception_i; same wrap rule.
REQ-032 A write to a counter half SHALL load that half with csr_data_i and suppress the whole 64-bit increment that cycle.
REQ-033 With no write, the low-half carry out SHALL increment the high half on the same edge.

Reset
REQ-034 Asynchronous reset SHALL set mstatus=0x00001800 (MPP=11) and mtvec, mepc, mcause, mtval, mscratch, mie, mcycle, minstret to 0.
REQ-035 During reset, mepc_q_o, mtvec_q_o and mstatus_q_o SHALL read their reset values (0, 0, 0x00001800); rd_data_o follows the reset state.
REQ-036 Reset asserted mid-operation SHALL override any pending write, exception or count.

Verification
REQ-037 Write mtvec=0x8000_0103 -> next cycle mtvec_q_o=0x8000_0100; read of 0x305 returns the same value.
REQ-038 mstatus MIE=1, then exception_i with mepc_i=0x1006, mcause_i=2, mtval_i=0 -> next cycle:
- mepc=0x1004, mcause=2
- mstatus=0x00001880 (MPIE=1, MIE=0, MPP=11)
REQ-039 exception_i and csr_wbk_v_i to mscratch=0xDEAD in the same cycle -> mscratch unchanged (0); trap CSRs updated.
REQ-040 Write mcycle=0xFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0.
REQ-041 retire_v_i=1 for 5 cycles, one of them with exception_i=1 -> minstret=4.
REQ-042 Read 0x7C0 -> rd_data_o=0, rd_illegal_o=1; write 0x7C0 -> no CSR changes.
